// File: rtl/reorder_buffer_pkg.sv
// rob_pkg: shared sizing, entry type encoding and the per-entry record for
// the reorder buffer. Imported by the interface, query port and top.
package rob_pkg;
  localparam int ROB_DEPTH_LOG = 5;
  localparam int ROB_DEPTH     = 1 << ROB_DEPTH_LOG;
  localparam int XLEN          = 32;

  typedef logic [ROB_DEPTH_LOG-1:0] rob_tag_t;

  typedef enum logic [1:0] {
    REG    = 2'd0,
    STORE  = 2'd1,
    BRANCH = 2'd2
  } rob_type_e;

  typedef struct packed {
    logic            busy;
    logic            ready;
    rob_type_e       typ;
    logic [4:0]      rd;
    logic [XLEN-1:0] val;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic            taken;
    logic [XLEN-1:0] target;
  } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: all dispatch / CDB / query / regfile / commit signals of
// the reorder buffer. master = environment (dispatch, CDB, regfile side),
// slave = the reorder buffer itself.
interface reorder_buffer_if;
  logic                          issue_en;
  rob_pkg::rob_type_e            issue_type;
  logic [4:0]                    issue_rd;
  logic [31:0]                   issue_pc;
  logic                          issue_pred_taken;
  logic                          full;
  rob_pkg::rob_tag_t             issue_tag;
  logic                          cdb_en;
  rob_pkg::rob_tag_t             cdb_tag;
  logic [31:0]                   cdb_val;
  logic                          cdb_taken;
  logic [31:0]                   cdb_target;
  rob_pkg::rob_tag_t             query1_tag, query2_tag;
  logic                          query1_ready, query2_ready;
  logic [31:0]                   query1_val, query2_val;
  logic                          dependency_set_en;
  logic [4:0]                    dependency_reg;
  rob_pkg::rob_tag_t             dependency_dependency;
  logic                          write_en;
  logic [4:0]                    write_id;
  rob_pkg::rob_tag_t             write_dependency;
  logic [31:0]                   write_val;
  logic                          store_commit_en;
  rob_pkg::rob_tag_t             store_commit_tag;
  logic                          flush;
  logic [31:0]                   flush_pc;

  modport master (
    output issue_en, issue_type, issue_rd, issue_pc, issue_pred_taken,
    output cdb_en, cdb_tag, cdb_val, cdb_taken, cdb_target,
    output query1_tag, query2_tag,
    input  full, issue_tag, query1_ready, query2_ready, query1_val, query2_val,
    input  dependency_set_en, dependency_reg, dependency_dependency,
    input  write_en, write_id, write_dependency, write_val,
    input  store_commit_en, store_commit_tag, flush, flush_pc
  );

  modport slave (
    input  issue_en, issue_type, issue_rd, issue_pc, issue_pred_taken,
    input  cdb_en, cdb_tag, cdb_val, cdb_taken, cdb_target,
    input  query1_tag, query2_tag,
    output full, issue_tag, query1_ready, query2_ready, query1_val, query2_val,
    output dependency_set_en, dependency_reg, dependency_dependency,
    output write_en, write_id, write_dependency, write_val,
    output store_commit_en, store_commit_tag, flush, flush_pc
  );
endinterface

// File: rtl/reorder_buffer_query.sv
// rob_query_port: operand lookup by tag.
//   tag_i          queried tag
//   avail_i        per-entry busy && ready
//   val_i          per-entry result value
//   cdb_en_i/cdb_tag_i/cdb_val_i  current CDB broadcast
//   ready_o/val_o  lookup result
// Macro ROB_BYPASS_EN: forward a matching CDB broadcast in the same cycle.
module rob_query_port
  import rob_pkg::*;
(
  input  rob_tag_t                        tag_i,
  input  logic [ROB_DEPTH-1:0]            avail_i,
  input  logic [ROB_DEPTH-1:0][XLEN-1:0]  val_i,
  input  logic                            cdb_en_i,
  input  rob_tag_t                        cdb_tag_i,
  input  logic [XLEN-1:0]                 cdb_val_i,
  output logic                            ready_o,
  output logic [XLEN-1:0]                 val_o
);
`ifdef ROB_BYPASS_EN
  logic hit;
  assign hit     = cdb_en_i && (cdb_tag_i == tag_i);
  assign ready_o = hit || avail_i[tag_i];
  assign val_o   = hit ? cdb_val_i : val_i[tag_i];
`else
  // Registered state only; the CDB lands in the table one cycle later.
  logic unused_cdb;
  assign unused_cdb = ^{cdb_en_i, cdb_tag_i, cdb_val_i};
  assign ready_o    = avail_i[tag_i];
  assign val_o      = val_i[tag_i];
`endif
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order commit buffer.
//   clk, rst   clock, synchronous active-high reset
//   rob        reorder_buffer_if.slave: issue (tag alloc + regfile rename),
//              CDB completion, two operand queries, in-order commit to the
//              regfile / store unit, and mispredict flush with redirect pc.
// Macro ROB_BYPASS_EN: queries see a same-cycle CDB hit (see rob_query_port).
module reorder_buffer
  import rob_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  reorder_buffer_if.slave  rob
);
  localparam int NQ = 2;
  localparam logic [ROB_DEPTH_LOG:0] FULL_CNT = (ROB_DEPTH_LOG+1)'(ROB_DEPTH);

  rob_entry_t [ROB_DEPTH-1:0] ent_q, ent_d;
  rob_tag_t                   head_q, head_d, tail_q, tail_d;
  logic [ROB_DEPTH_LOG:0]     count_q, count_d;

  rob_entry_t hd;
  logic       full, commit, mispredict, accept;

  assign hd         = ent_q[head_q];
  assign full       = (count_q == FULL_CNT);
  // All outputs are forced to zero during the reset cycle.
  assign commit     = !rst && (count_q != '0) && hd.busy && hd.ready;
  assign mispredict = commit && (hd.typ == BRANCH) && (hd.taken != hd.pred_taken);
  assign accept     = !rst && rob.issue_en && !full && !mispredict;

  assign rob.full                  = !rst && full;
  assign rob.issue_tag             = rst ? '0 : tail_q;
  assign rob.dependency_set_en     = accept && (rob.issue_type == REG) && (rob.issue_rd != '0);
  assign rob.dependency_reg        = rst ? '0 : rob.issue_rd;
  assign rob.dependency_dependency = rst ? '0 : tail_q;

  // rd==0 still retires, it just never writes the regfile.
  assign rob.write_en         = commit && (hd.typ == REG) && (hd.rd != '0);
  assign rob.write_id         = rob.write_en ? hd.rd  : '0;
  assign rob.write_dependency = rob.write_en ? head_q : '0;
  assign rob.write_val        = rob.write_en ? hd.val : '0;
  assign rob.store_commit_en  = commit && (hd.typ == STORE);
  assign rob.store_commit_tag = rob.store_commit_en ? head_q : '0;
  assign rob.flush            = mispredict;
  assign rob.flush_pc         = !mispredict ? '0 :
                                hd.taken    ? hd.target : hd.pc + 32'd4;

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rob.cdb_en && ent_q[rob.cdb_tag].busy) begin
      ent_d[rob.cdb_tag].ready  = 1'b1;
      ent_d[rob.cdb_tag].val    = rob.cdb_val;
      ent_d[rob.cdb_tag].taken  = rob.cdb_taken;
      ent_d[rob.cdb_tag].target = rob.cdb_target;
    end
    if (commit) begin
      ent_d[head_q].busy  = 1'b0;
      ent_d[head_q].ready = 1'b0;
      head_d              = head_q + 1'b1;
    end
    // Issue lands last so a stale CDB write to the tail slot cannot mark it ready.
    if (accept) begin
      ent_d[tail_q] = '{busy: 1'b1, ready: 1'b0, typ: rob.issue_type, rd: rob.issue_rd,
                        val: '0, pc: rob.issue_pc, pred_taken: rob.issue_pred_taken,
                        taken: 1'b0, target: '0};
      tail_d        = tail_q + 1'b1;
    end
    case ({accept, commit})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (mispredict) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        ent_d[i].busy  = 1'b0;
        ent_d[i].ready = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Operand lookup ports
  logic [ROB_DEPTH-1:0]           avail;
  logic [ROB_DEPTH-1:0][XLEN-1:0] vals;
  rob_tag_t [NQ-1:0]              q_tag;
  logic [NQ-1:0]                  q_rdy;
  logic [NQ-1:0][XLEN-1:0]        q_val;

  for (genvar e = 0; e < ROB_DEPTH; e++) begin : g_tab
    assign avail[e] = ent_q[e].busy && ent_q[e].ready;
    assign vals[e]  = ent_q[e].val;
  end

  assign q_tag[0] = rob.query1_tag;
  assign q_tag[1] = rob.query2_tag;

  for (genvar g = 0; g < NQ; g++) begin : g_qp
    rob_query_port u_qp (
      .tag_i     (q_tag[g]),
      .avail_i   (avail),
      .val_i     (vals),
      .cdb_en_i  (rob.cdb_en),
      .cdb_tag_i (rob.cdb_tag),
      .cdb_val_i (rob.cdb_val),
      .ready_o   (q_rdy[g]),
      .val_o     (q_val[g])
    );
  end

  assign rob.query1_ready = !rst && q_rdy[0];
  assign rob.query2_ready = !rst && q_rdy[1];
  assign rob.query1_val   = rst ? '0 : q_val[0];
  assign rob.query2_val   = rst ? '0 : q_val[1];
endmodule
